// File: rtl/scan_pkg.sv
// scan_pkg: shared types and widths for the digit scanner (digit_scan_ctrl).
// Holds the scan state encoding, nibble/digit/frame widths and a helper that
// locates the most significant nonzero nibble of a frame.
package scan_pkg;

    localparam int NIB_W   = 4;
    localparam int DIG_W   = 3;
    localparam int FRAME_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Index of the highest nonzero nibble in a frame; 0 when the frame is all zero.
    function automatic logic [DIG_W-1:0] msd_index(input logic [FRAME_W-1:0] frame);
        logic [DIG_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < FRAME_W / NIB_W; i++) begin
            if (frame[i*NIB_W +: NIB_W] != '0) begin
                idx = DIG_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: frame upload channel (valid/ready plus 32-bit frame).
// master = upstream frame source, slave = the scanner.
interface digit_scan_ctrl_if;
    import scan_pkg::*;

    logic               frame_valid;
    logic               frame_ready;
    logic [FRAME_W-1:0] frame_data;

    modport master (output frame_valid, output frame_data, input frame_ready);
    modport slave  (input frame_valid, input frame_data, output frame_ready);

endinterface

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running prescaler 0..TERM-1 with synchronous clear.
// o_tc is high while the count sits on its terminal value, so a state that
// enables the counter from a cleared start lasts exactly TERM cycles.
module scan_tick_gen #(
    parameter int TERM = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = (TERM > 1) ? $clog2(TERM) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tc = (r_cnt == CW'(TERM - 1));

    // Count up while enabled, wrapping on the terminal value; clear dominates.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed 8-digit display scanner.
// Double-buffered frame (pending -> active on frame boundaries or while idle),
// SHOW/BLANK scan per digit with a blanking gap against ghosting.
// Optional macro LEADING_ZERO_BLANK_EN: blank digits above the most
// significant nonzero nibble during SHOW (digit 0 always shown).
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int BLANK_CYC  = 2,
    parameter int NUM_DIGITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    digit_scan_ctrl_if.slave fbus,
    output logic [DIG_W-1:0] digit,
    output logic [NIB_W-1:0] nibble,
    output logic             blank,
    output logic             frame_done
);

    state_t             r_state;
    logic [FRAME_W-1:0] r_active;
    logic [FRAME_W-1:0] r_pending;
    logic               r_pend_valid;
    logic               r_ready;
    logic [DIG_W-1:0]   r_digit;
    logic [NIB_W-1:0]   r_nibble;
    logic               r_blank;
    logic               r_done;

    logic               w_show_tc;
    logic               w_blank_tc;
    logic               w_take;
    logic               w_last;
    logic               w_boundary;
    logic               w_promote;
    logic               w_pend_valid_next;
    logic               w_sup;
    logic [FRAME_W-1:0] w_next_active;
    logic [DIG_W-1:0]   w_next_digit;
    logic [NIB_W-1:0]   w_next_nibble;

    scan_tick_gen #(.TERM(DIV)) u_show_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (r_state != SHOW),
        .i_en  (r_state == SHOW),
        .o_tc  (w_show_tc)
    );

    scan_tick_gen #(.TERM(BLANK_CYC)) u_blank_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (r_state != BLANK),
        .i_en  (r_state == BLANK),
        .o_tc  (w_blank_tc)
    );

    assign w_take     = fbus.frame_valid && r_ready;
    assign w_last     = (r_digit == DIG_W'(NUM_DIGITS - 1));
    assign w_boundary = en && (r_state == BLANK) && w_blank_tc && w_last;
    // Idle promotes immediately so a first frame does not wait for a wrap.
    assign w_promote  = r_pend_valid && ((r_state == IDLE) || w_boundary);
    // take needs an empty pending buffer and promote a full one, so they never coincide.
    assign w_pend_valid_next = w_take ? 1'b1 : (w_promote ? 1'b0 : r_pend_valid);

    assign w_next_active = w_promote ? r_pending : r_active;
    assign w_next_digit  = ((r_state == BLANK) && !w_last) ? r_digit + 1'b1 : '0;
    assign w_next_nibble = w_next_active[NIB_W*int'(w_next_digit) +: NIB_W];

`ifdef LEADING_ZERO_BLANK_EN
    assign w_sup = (w_next_digit > msd_index(w_next_active));
`else
    assign w_sup = 1'b0;
`endif

    assign fbus.frame_ready = r_ready;
    assign digit            = r_digit;
    assign nibble           = r_nibble;
    assign blank            = r_blank;
    assign frame_done       = r_done;

    // Scan FSM, frame double buffer and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_digit      <= '0;
            r_nibble     <= '0;
            r_blank      <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_active     <= w_next_active;
            r_pend_valid <= w_pend_valid_next;
            r_ready      <= !w_pend_valid_next;
            if (w_take) begin
                r_pending <= fbus.frame_data;
            end

            case (r_state)
                IDLE: begin
                    r_blank <= 1'b1;
                    r_digit <= '0;
                    if (en) begin
                        r_state  <= SHOW;
                        r_nibble <= w_next_nibble;
                        r_blank  <= w_sup;
                    end
                end
                SHOW: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_blank <= 1'b1;
                        r_digit <= '0;
                    end else if (w_show_tc) begin
                        r_state <= BLANK;
                        r_blank <= 1'b1;
                    end
                end
                BLANK: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_blank <= 1'b1;
                        r_digit <= '0;
                    end else if (w_blank_tc) begin
                        r_state  <= SHOW;
                        r_digit  <= w_next_digit;
                        r_nibble <= w_next_nibble;
                        r_blank  <= w_sup;
                        r_done   <= w_last;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_blank <= 1'b1;
                    r_digit <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed bench for digit_scan_ctrl with a timeline model
// (digit/phase derived from elapsed scan cycles) checked every cycle, plus
// hand-computed spot checks. Macro LEADING_ZERO_BLANK_EN adds a suppression case.
module tb_digit_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BC    = 2;
    localparam int ND    = 8;
    localparam int P     = DIV + BC;
    localparam int FP    = P * ND;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] digit;
    logic [3:0] nibble;
    logic       blank;
    logic       frame_done;

    digit_scan_ctrl_if bus ();

    digit_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BC), .NUM_DIGITS(ND)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fbus       (bus),
        .digit      (digit),
        .nibble     (nibble),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    bit          m_init = 0;
    bit          m_run  = 0;
    bit          m_pv   = 0;
    int          m_t    = 0;
    logic [31:0] m_act  = '0;
    logic [31:0] m_pend = '0;
    logic [3:0]  m_nib  = '0;
    int          e_digit = 0;
    int          e_nib   = 0;
    int          e_blank = 1;
    int          e_ready = 1;
    int          e_done  = 0;

    function automatic bit lz_hidden(input logic [31:0] f, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        int top;
        top = 0;
        for (int i = 7; i >= 0; i--) begin
            if (((f >> (4 * i)) & 32'hF) != 0 && top == 0) top = i;
        end
        return d > top;
`else
        return (f == 32'h0) && (d < 0);
`endif
    endfunction

    initial begin
        bit take;
        bit boundary;
        int d;
        forever begin
            @(posedge clk);
            cyc++;
            m_init = 1;
            if (!rst_n) begin
                m_run = 0; m_t = 0; m_pv = 0; m_act = '0; m_pend = '0;
                m_nib = '0; e_done = 0;
            end else begin
                take     = bus.frame_valid && !m_pv;
                boundary = m_run && en && (((m_t + 1) % FP) == 0);
                if (m_pv && (boundary || !m_run)) begin
                    m_act = m_pend;
                    m_pv  = 0;
                end
                if (take) begin
                    m_pend = bus.frame_data;
                    m_pv   = 1;
                end
                e_done = int'(boundary);
                if (m_run && !en) m_run = 0;
                else if (m_run) m_t = (m_t + 1) % FP;
                else if (en) begin
                    m_run = 1;
                    m_t   = 0;
                end
            end
            e_ready = int'(!m_pv);
            if (m_run) begin
                d       = (m_t / P) % ND;
                e_digit = d;
                m_nib   = m_act[4*d +: 4];
                e_nib   = int'(m_nib);
                e_blank = int'(((m_t % P) >= DIV) || lz_hidden(m_act, d));
            end else begin
                e_digit = 0;
                e_nib   = int'(m_nib);
                e_blank = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("digit",       int'(digit),           e_digit);
                chk("nibble",      int'(nibble),          e_nib);
                chk("blank",       int'(blank),           e_blank);
                chk("frame_ready", int'(bus.frame_ready), e_ready);
                chk("frame_done",  int'(frame_done),      e_done);
            end
        end
    end

    // ---------------- stimulus helpers (called right after a negedge) ----------------
    task automatic send(input logic [31:0] d, output bit done_at_accept);
        bit ok;
        ok = 0;
        done_at_accept = 0;
        bus.frame_valid = 1'b1;
        bus.frame_data  = d;
        for (int n = 0; n < 300; n++) begin
            if (bus.frame_ready) begin
                ok = 1;
                done_at_accept = frame_done;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout data=%08h got=no_accept exp=accept", d);
            bus.frame_valid = 1'b0;
        end else begin
            @(negedge clk);
            bus.frame_valid = 1'b0;
            bus.frame_data  = 32'hDEAD_BEEF;
            $display("XFER cyc=%0d data=%08h", cyc, d);
        end
    endtask

    task automatic wait_digit(input int d, input bit need_show);
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (int'(digit) == d && (!need_show || !blank)) begin
                ok = 1;
                break;
            end
        end
        chk("wait_digit", int'(ok), 1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1;
                break;
            end
        end
        chk("wait_done", int'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit dn;
        int t0;
        rst_n = 1'b0;
        en    = 1'b0;
        bus.frame_valid = 1'b0;
        bus.frame_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_digit", int'(digit), 0);
        chk("rst_blank", int'(blank), 1);
        chk("rst_ready", int'(bus.frame_ready), 1);
        chk("rst_done",  int'(frame_done), 0);

        // Load while idle, then scan.
        send(32'h7654_3210, dn);
        chk("ready_after_load", int'(bus.frame_ready), 0);
        @(negedge clk);
        en = 1'b1;
        wait_digit(3, 1);
        chk("scan_nib3", int'(nibble), 3);
        wait_done();
        t0 = cyc;
        wait_done();
        chk("frame_period", cyc - t0, 48);

        // Double buffer: new frame lands only at the boundary.
        wait_digit(3, 1);
        send(32'hFFFF_FFFF, dn);
        chk("db_ready_low", int'(bus.frame_ready), 0);
        wait_digit(6, 1);
        chk("db_old_nib6", int'(nibble), 6);
        wait_done();
        chk("db_ready_back", int'(bus.frame_ready), 1);
        chk("db_new_nib0",  int'(nibble), 15);

        // Backpressure: held offer is accepted right after the boundary.
        send(32'h1234_5678, dn);
        send(32'hAAAA_AAAA, dn);
        chk("bp_accept_at_done", int'(dn), 1);
        wait_done();
        chk("bp_nibA", int'(nibble), 10);

        // Enable drop mid-frame.
        wait_digit(5, 1);
        en = 1'b0;
        @(negedge clk);
        chk("endrop_digit", int'(digit), 0);
        chk("endrop_blank", int'(blank), 1);
        chk("endrop_done",  int'(frame_done), 0);
        repeat (5) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("reen_blank", int'(blank), 0);
        chk("reen_nib",   int'(nibble), 10);

        // Reset mid-frame discards frames.
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_ready", int'(bus.frame_ready), 1);
        chk("mrst_blank", int'(blank), 1);
        en = 1'b1;
        @(negedge clk);
        chk("mrst_nib0", int'(nibble), 0);

`ifdef LEADING_ZERO_BLANK_EN
        en = 1'b0;
        @(negedge clk);
        send(32'h0000_0305, dn);
        @(negedge clk);
        en = 1'b1;
        wait_digit(2, 1);
        chk("lz_nib2", int'(nibble), 3);
        wait_digit(4, 0);
        chk("lz_blank4", int'(blank), 1);
`endif

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
